// File: rtl/truth_table_sweeper_if.sv
// Bus between the truth-table sweeper (slave) and the harness that owns the
// netlist and control strobes (master).
// Optional: TT_MISMATCH_MASK_EN adds the mismatch_mask result.
interface truth_table_sweeper_if;
  logic        start;
  logic        abort;
  logic        dut_out;
  logic        drv_in1;
  logic        drv_in2;
  logic        drv_in3;
  logic        drv_in4;
  logic        busy;
  logic        done;
  logic        result_valid;
  logic [15:0] captured_tt;
  logic        pass;
  logic [3:0]  row;
`ifdef TT_MISMATCH_MASK_EN
  logic [15:0] mismatch_mask;
`endif

  modport slave (
    input  start, abort, dut_out,
    output drv_in1, drv_in2, drv_in3, drv_in4,
    output busy, done, result_valid, captured_tt, pass, row
`ifdef TT_MISMATCH_MASK_EN
    , output mismatch_mask
`endif
  );

  modport master (
    output start, abort, dut_out,
    input  drv_in1, drv_in2, drv_in3, drv_in4,
    input  busy, done, result_valid, captured_tt, pass, row
`ifdef TT_MISMATCH_MASK_EN
    , input mismatch_mask
`endif
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives the 16 rows of a 4-input netlist, lets each row
// settle, samples the synchronised output and assembles the truth-table word
// (row 0 in the MSB), then compares it with EXPECTED.
// Optional: TT_MISMATCH_MASK_EN registers captured_tt ^ EXPECTED in DONE.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter logic [15:0] EXPECTED      = 16'hB8AD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_sweeper_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [3:0]  r_row;
  logic [3:0]  r_drv;
  logic [15:0] r_tt;
  logic        r_valid;
  logic        r_pass;
  logic        r_sync1;
  logic        r_sync2;
  logic        w_accept;
`ifdef TT_MISMATCH_MASK_EN
  logic [15:0] r_mask;
`endif

  assign w_accept = bus.start && !bus.abort;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; abort wins in every active state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_DRIVE;
      S_DRIVE: begin
        if (bus.abort)                                w_next = S_IDLE;
        else if (r_cnt == 8'(SETTLE_CYCLES - 1))      w_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (bus.abort)             w_next = S_IDLE;
        else if (r_row == 4'd15)   w_next = S_DONE;
        else                       w_next = S_DRIVE;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Two-flop synchroniser for the asynchronous netlist output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.dut_out;
      r_sync2 <= r_sync1;
    end
  end

  // Sweep datapath: settle counter, row index, drive bits and results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_row   <= '0;
      r_drv   <= '0;
      r_tt    <= '0;
      r_valid <= 1'b0;
      r_pass  <= 1'b0;
`ifdef TT_MISMATCH_MASK_EN
      r_mask  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_row   <= '0;
            r_drv   <= '0;
            r_tt    <= '0;
            r_valid <= 1'b0;
            r_pass  <= 1'b0;
`ifdef TT_MISMATCH_MASK_EN
            r_mask  <= '0;
`endif
          end
        end
        S_DRIVE, S_SAMPLE, S_DONE: begin
          if (bus.abort) begin
            // captured_tt deliberately keeps its partial content
            r_cnt   <= '0;
            r_row   <= '0;
            r_drv   <= '0;
            r_valid <= 1'b0;
            r_pass  <= 1'b0;
`ifdef TT_MISMATCH_MASK_EN
            r_mask  <= '0;
`endif
          end else if (r_state == S_DRIVE) begin
            r_cnt <= r_cnt + 8'd1;
          end else if (r_state == S_SAMPLE) begin
            r_tt[4'd15 - r_row] <= r_sync2;
            r_cnt <= '0;
            if (r_row == 4'd15) begin
              r_drv <= '0;
            end else begin
              r_row <= r_row + 4'd1;
              r_drv <= r_row + 4'd1;
            end
          end else begin
            r_valid <= 1'b1;
            r_pass  <= (r_tt == EXPECTED);
            r_row   <= '0;
`ifdef TT_MISMATCH_MASK_EN
            r_mask  <= r_tt ^ EXPECTED;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.drv_in1      = r_drv[3];
  assign bus.drv_in2      = r_drv[2];
  assign bus.drv_in3      = r_drv[1];
  assign bus.drv_in4      = r_drv[0];
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = (r_state == S_DONE);
  assign bus.result_valid = r_valid;
  assign bus.captured_tt  = r_tt;
  assign bus.pass         = r_pass;
  assign bus.row          = r_row;
`ifdef TT_MISMATCH_MASK_EN
  assign bus.mismatch_mask = r_mask;
`endif

endmodule
